stream_narrow_mton: RTL
=======================

Name: stream_narrow_mton

Overview:
- Parametrised FIFO-style stream narrower: accepts IN_WORDS words per beat and emits OUT_WORDS words per beat, for any ratio with OUT_WORDS < IN_WORDS (integer multiple not required).
- Successor to the fixed 32-word narrowers in stream_tools, used between wide memory/DMA streams and narrow CNN compute lanes.
- Adds packet-end handling: a partial final input beat, flushing of a partial final output beat, and a last flag with valid-word count.
- Full valid/ready flow control on both sides.

Parameters:
- WORD_W, 8, bits per word.
- IN_WORDS, 32, words per input beat.
- OUT_WORDS, 6, words per output beat; must satisfy 1 <= OUT_WORDS < IN_WORDS.
- SB_WORDS, 48, internal buffer depth in words; must be >= IN_WORDS + OUT_WORDS - 1 (elaboration-time assertion).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stream_in  in  IN_WORDS*WORD_W  input words; word 0 in bits [WORD_W-1:0] is consumed first.
- stream_in_valid  in  1  input beat valid.
- stream_in_last  in  1  marks final beat of packet.
- stream_in_words  in  $clog2(IN_WORDS+1)  valid words in beat (low words); honoured only when stream_in_last=1, otherwise treated as IN_WORDS.
- stream_in_ready  out  1  input accepted when valid&ready.
- stream_out  out  OUT_WORDS*WORD_W  output words; word 0 in the low bits is oldest.
- stream_out_valid  out  1  output beat valid.
- stream_out_last  out  1  final beat of packet.
- stream_out_words  out  $clog2(OUT_WORDS+1)  valid words in the output beat.
- stream_out_ready  in  1  downstream accepts.

Behaviour:
State registers:
- buf: SB_WORDS words.
- count: 0..SB_WORDS.
- last_pending: 1 bit.

Input side:
- stream_in_ready = !last_pending && (count <= SB_WORDS - IN_WORDS).
- Ready is a function of registers only; it never depends on stream_in_valid or on a pop in the same cycle.

Output side:
- stream_out_valid = (count >= OUT_WORDS) || last_pending.
- final = last_pending && (count <= OUT_WORDS).
- stream_out_last = final.
- stream_out_words = final ? count : OUT_WORDS.
- stream_out = buf words 0..OUT_WORDS-1. Word positions >= count are driven to zero.
- All outputs are derived combinationally from registers. There is no combinational path from stream_in_* to stream_out_*.

Latency:
- A beat accepted in cycle N is visible at the output from cycle N+1, provided enough words are buffered.

Pop:
- On valid&ready at the output, buf shifts down by stream_out_words and count decreases by stream_out_words.
- If final, last_pending clears.

Push:
- On valid&ready at the input, the incoming words are written at index (count after pop), and count increases by the effective word count.
- If stream_in_last=1, last_pending is set.

Simultaneous push and pop:
- Pop is applied first, then push, in the same cycle.
- A push and a final pop cannot coincide, because ready is low while last_pending=1.

Word order:
- Strict FIFO. No words are lost or reordered across beat boundaries.

Boundaries:
- count = SB_WORDS - IN_WORDS: ready=1.
- One word more than that: ready=0.
- count = 0 with no last_pending: valid=0.
- Last beat with stream_in_words=0 into an empty buffer: emits a single beat with words=0, last=1, data zero.
- Last beat leaving count an exact multiple of OUT_WORDS: the final beat is full (words=OUT_WORDS, last=1). No extra empty beat follows.
- stream_in_words > IN_WORDS: clamped to IN_WORDS.
- The next packet's first beat is accepted the cycle after the final output beat is popped.

Reset:
- Synchronous. count=0, last_pending=0, buf contents don't-care.
- Outputs after reset: stream_in_ready=1, stream_out_valid=0, stream_out_last=0, stream_out_words=0, stream_out=0.
- A reset in mid-packet discards all buffered words. Neither side sees a partial handshake after the reset edge.

Decomposition:
- Package stream_tools_pkg:
  - function for valid-word count width (clog2(n+1)).
  - parameter-legality check macros/assertions.
- One sub-module, stream_word_shiftbuf:
  - parametrised WORD_W/SB_WORDS/IN_WORDS/OUT_WORDS storage.
  - implements pop-then-append with variable pop and push counts, and exposes count.
- The top level holds last_pending, the ready/valid/last logic, and output zero-masking.

Test Plan:
- Continuous stream, defaults, 3 full input beats with incrementing bytes 0..95, out_ready=1 -> 16 beats of 6 bytes in order 0..95; no last; in_ready never stalls below throughput.
- Packet of 2 beats, second last with words=5 (37 bytes) -> 6 full beats then final beat words=1, last=1, upper 5 bytes zero.
- Last beat with words=4 after one full beat (36 bytes, multiple of 6) -> exactly 6 beats, sixth has last=1 and words=6; no empty beat follows.
- Backpressure: out_ready held 0 -> in_ready drops when count > 16; random out_ready 50% over 100 beats -> output sequence matches scoreboard, no drops or duplicates.
- Empty last: in_last=1, words=0 into an empty buffer -> one output beat, valid=1, last=1, words=0, data 0; in_ready=0 until it is popped.
- Reset asserted with 20 words buffered and last_pending=1 -> next cycle valid=0, ready=1, words=0; a new packet afterwards is emitted cleanly from its word 0.

Source files
------------

// File: rtl/stream_tools_pkg.sv
// Shared helpers for the stream_tools word-stream blocks: count-width sizing
// and the parameter legality rule for the narrowers.
package stream_tools_pkg;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // The buffer must hold a full input beat on top of a partial output beat.
  function automatic bit narrow_params_ok(input int in_words, input int out_words,
                                          input int sb_words);
    return (out_words >= 1) && (out_words < in_words) &&
           (sb_words >= in_words + out_words - 1);
  endfunction

endpackage

// File: rtl/stream_word_shiftbuf.sv
// Word-granular shift buffer: each cycle pops a variable number of words from
// the head, then appends a variable number of words behind what remains.
module stream_word_shiftbuf
  import stream_tools_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int SB_WORDS  = 48,
  parameter int IN_WORDS  = 32,
  parameter int OUT_WORDS = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pop_en,
  input  logic [count_width(OUT_WORDS)-1:0]   pop_words,
  input  logic                                push_en,
  input  logic [count_width(IN_WORDS)-1:0]    push_words,
  input  logic [IN_WORDS*WORD_W-1:0]          push_data,
  output logic [count_width(SB_WORDS)-1:0]    count,
  output logic [OUT_WORDS*WORD_W-1:0]         head
);

  localparam int CW_SB = count_width(SB_WORDS);

  logic [WORD_W-1:0] words_q [SB_WORDS];
  logic [WORD_W-1:0] words_d [SB_WORDS];
  logic [CW_SB-1:0]  count_q;
  logic [CW_SB-1:0]  count_d;
  int                pop_n;
  int                push_n;
  int                base;
  int                src;
  int                off;

  // Pop first, so the append lands directly behind the surviving words.
  always_comb begin
    pop_n  = pop_en ? int'(pop_words) : 0;
    push_n = push_en ? int'(push_words) : 0;
    base   = int'(count_q) - pop_n;
    src    = 0;
    off    = 0;
    for (int i = 0; i < SB_WORDS; i++) begin
      words_d[i] = words_q[i];
      src = i + pop_n;
      if (src < SB_WORDS) begin
        words_d[i] = words_q[src];
      end
      off = i - base;
      if (off >= 0 && off < push_n) begin
        words_d[i] = push_data[off*WORD_W +: WORD_W];
      end
    end
    count_d = CW_SB'(base + push_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  always_comb begin
    for (int w = 0; w < OUT_WORDS; w++) begin
      head[w*WORD_W +: WORD_W] = words_q[w];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stream_narrow_mton.sv
// Stream narrower: IN_WORDS words per input beat to OUT_WORDS words per output
// beat, with packet-end handling (partial last beat, flush, last/word count).
module stream_narrow_mton
  import stream_tools_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int IN_WORDS  = 32,
  parameter int OUT_WORDS = 6,
  parameter int SB_WORDS  = 48
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_WORDS*WORD_W-1:0]         stream_in,
  input  logic                               stream_in_valid,
  input  logic                               stream_in_last,
  input  logic [count_width(IN_WORDS)-1:0]   stream_in_words,
  output logic                               stream_in_ready,
  output logic [OUT_WORDS*WORD_W-1:0]        stream_out,
  output logic                               stream_out_valid,
  output logic                               stream_out_last,
  output logic [count_width(OUT_WORDS)-1:0]  stream_out_words,
  input  logic                               stream_out_ready
);

  localparam int CW_IN  = count_width(IN_WORDS);
  localparam int CW_OUT = count_width(OUT_WORDS);
  localparam int CW_SB  = count_width(SB_WORDS);

  if (!narrow_params_ok(IN_WORDS, OUT_WORDS, SB_WORDS)) begin : g_bad_params
    $error("stream_narrow_mton: need 1 <= OUT_WORDS < IN_WORDS and SB_WORDS >= IN_WORDS+OUT_WORDS-1");
  end

  logic [CW_SB-1:0]            count;
  logic [OUT_WORDS*WORD_W-1:0] head;
  logic                        last_pending_q;
  logic                        last_pending_d;
  logic                        final_beat;
  logic                        pop_en;
  logic                        push_en;
  logic [CW_IN-1:0]            push_words;

  stream_word_shiftbuf #(
    .WORD_W   (WORD_W),
    .SB_WORDS (SB_WORDS),
    .IN_WORDS (IN_WORDS),
    .OUT_WORDS(OUT_WORDS)
  ) u_shiftbuf (
    .clk       (clk),
    .rst       (rst),
    .pop_en    (pop_en),
    .pop_words (stream_out_words),
    .push_en   (push_en),
    .push_words(push_words),
    .push_data (stream_in),
    .count     (count),
    .head      (head)
  );

  // Everything visible at the ports comes from registered state only; the word
  // count reads zero whenever no beat is offered.
  always_comb begin
    stream_in_ready  = !last_pending_q && (int'(count) <= SB_WORDS - IN_WORDS);
    final_beat       = last_pending_q && (int'(count) <= OUT_WORDS);
    stream_out_valid = (int'(count) >= OUT_WORDS) || last_pending_q;
    stream_out_last  = final_beat;
    if (!stream_out_valid) begin
      stream_out_words = '0;
    end else if (final_beat) begin
      stream_out_words = CW_OUT'(count);
    end else begin
      stream_out_words = CW_OUT'(OUT_WORDS);
    end
    for (int w = 0; w < OUT_WORDS; w++) begin
      stream_out[w*WORD_W +: WORD_W] = (w < int'(count)) ? head[w*WORD_W +: WORD_W] : '0;
    end
  end

  always_comb begin
    pop_en  = stream_out_valid && stream_out_ready;
    push_en = stream_in_valid && stream_in_ready;
    if (!stream_in_last || int'(stream_in_words) > IN_WORDS) begin
      push_words = CW_IN'(IN_WORDS);
    end else begin
      push_words = stream_in_words;
    end
    last_pending_d = last_pending_q;
    if (pop_en && final_beat) begin
      last_pending_d = 1'b0;
    end
    if (push_en && stream_in_last) begin
      last_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pending_q <= 1'b0;
    end else begin
      last_pending_q <= last_pending_d;
    end
  end

endmodule
